// File: rtl/rs_gf256_inv_arb.sv
// Round-robin arbiter/sequencer sharing one multi-cycle GF(256) inverter among N_REQ
// requesters; zero operands and inverter timeouts are answered locally with an error flag.
module rs_gf256_inv_arb #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_operand,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_done,
  output logic [7:0]         o_result,
  output logic               o_err,
  output logic               o_inv_start,
  output logic [7:0]         o_inv_operand,
  input  logic               i_inv_done,
  input  logic [7:0]         i_inv_result
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LastRst = IW'(N_REQ - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        state_q;
  logic [IW-1:0] last_q;
  logic [IW-1:0] owner_q;
  logic [CW-1:0] cnt_q;

  logic [7:0]       op_arr [N_REQ];
  logic             pick_valid;
  logic [IW-1:0]    pick;
  logic [N_REQ-1:0] pick_oh;
  logic [7:0]       pick_op;

  for (genvar g = 0; g < N_REQ; g++) begin : g_op
    assign op_arr[g] = i_operand[8*g +: 8];
  end

  // Search ascends from last owner + 1 with wrap; the last owner itself is checked last.
  always_comb begin
    int unsigned idx;
    pick_valid = 1'b0;
    pick       = last_q;
    idx        = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_valid && i_req[IW'(idx)]) begin
        pick_valid = 1'b1;
        pick       = IW'(idx);
      end
    end
  end

  assign pick_oh = N_REQ'(1) << pick;
  assign pick_op = op_arr[pick];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      last_q        <= LastRst;
      owner_q       <= '0;
      cnt_q         <= '0;
      o_gnt         <= '0;
      o_done        <= '0;
      o_result      <= 8'h00;
      o_err         <= 1'b0;
      o_inv_start   <= 1'b0;
      o_inv_operand <= 8'h00;
    end else begin
      o_done      <= '0;
      o_result    <= 8'h00;
      o_err       <= 1'b0;
      o_inv_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            owner_q       <= pick;
            o_gnt         <= pick_oh;
            o_inv_operand <= pick_op;
            if (pick_op == 8'h00) begin
              o_done  <= pick_oh;
              o_err   <= 1'b1;
              state_q <= StResp;
            end else begin
              o_inv_start <= 1'b1;
              state_q     <= StIssue;
            end
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A done coinciding with the last allowed cycle still counts as success.
          if (i_inv_done) begin
            o_done   <= o_gnt;
            o_result <= i_inv_result;
            state_q  <= StResp;
          end else if (cnt_q == CntLast) begin
            o_done  <= o_gnt;
            o_err   <= 1'b1;
            state_q <= StResp;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          last_q  <= owner_q;
          o_gnt   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_gf256_inv_arb.sv
// Directed bench for rs_gf256_inv_arb: table of single operations plus round-robin,
// timeout/late-done and reset-mid-wait sequences against a behavioural inverter.
module tb_rs_gf256_inv_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] operand;
  logic [1:0]  gnt, done;
  logic [7:0]  result, inv_operand, inv_result;
  logic        err, inv_start, inv_done;

  logic        mdl_done, force_done;
  logic [7:0]  mdl_res, mdl_op;
  int          mdl_rem;
  int          inv_lat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rs_gf256_inv_arb #(
    .N_REQ   (2),
    .TIMEOUT (32)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_operand     (operand),
    .o_gnt         (gnt),
    .o_done        (done),
    .o_result      (result),
    .o_err         (err),
    .o_inv_start   (inv_start),
    .o_inv_operand (inv_operand),
    .i_inv_done    (inv_done),
    .i_inv_result  (inv_result)
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gf_mul(a, 8'(c)) == 8'h01) r = 8'(c);
    end
    return r;
  endfunction

  // Inverter model: done pulses inv_lat cycles after start; inv_lat == 0 never answers.
  always @(posedge clk) begin
    if (rst) begin
      mdl_done <= 1'b0;
      mdl_rem  <= 0;
      mdl_res  <= 8'h00;
      mdl_op   <= 8'h00;
    end else begin
      mdl_done <= 1'b0;
      if (inv_start) begin
        mdl_op <= inv_operand;
        if (inv_lat == 1) begin
          mdl_done <= 1'b1;
          mdl_res  <= gf_inv(inv_operand);
        end else if (inv_lat > 1) begin
          mdl_rem <= inv_lat - 1;
        end
      end else if (mdl_rem > 0) begin
        mdl_rem <= mdl_rem - 1;
        if (mdl_rem == 1) begin
          mdl_done <= 1'b1;
          mdl_res  <= gf_inv(mdl_op);
        end
      end
    end
  end

  assign inv_done   = mdl_done | force_done;
  assign inv_result = mdl_res;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         idx;
    logic [7:0] op;
    int         lat;
    int         late;
    logic [1:0] e_done;
    int         e_cyc;
    logic [7:0] e_res;
    logic       e_err;
    int         e_start;
  } vec_t;

  // Cycle 0 is the negedge where the request is raised; the next posedge samples it in IDLE.
  task automatic run_vec(input string tag, input vec_t v);
    int         done_cyc = -1;
    int         start_cyc = -1;
    int         n_start = 0;
    int         n_done = 0;
    logic [1:0] dv = 2'b00;
    logic [7:0] res = 8'h00;
    logic       e = 1'b0;
    logic       oh_ok = 1'b1;
    inv_lat = v.lat;
    @(negedge clk);
    req[v.idx] = 1'b1;
    operand[8*v.idx +: 8] = v.op;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      force_done = (c == v.late);
      if (inv_start) begin
        n_start++;
        if (start_cyc < 0) start_cyc = c;
      end
      if (gnt != 2'b00 && !$onehot(gnt)) oh_ok = 1'b0;
      if (done != 2'b00) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c;
          dv = done;
          res = result;
          e = err;
          req[v.idx] = 1'b0;
        end
      end
    end
    force_done = 1'b0;
    req = 2'b00;
    chk({tag, " done_vec"}, dv, v.e_done);
    chk({tag, " done_cyc"}, done_cyc, v.e_cyc);
    chk({tag, " result"}, res, v.e_res);
    chk({tag, " err"}, e, v.e_err);
    chk({tag, " start_cyc"}, start_cyc, v.e_start);
    chk({tag, " n_start"}, n_start, (v.e_start < 0) ? 0 : 1);
    chk({tag, " n_done"}, n_done, 1);
    chk({tag, " gnt_onehot"}, oh_ok, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int         n;
    int         d_idx[4];
    int         d_cyc[4];
    logic [7:0] d_res[4];
    int         s_cyc[4];
    int         ns;
    logic [1:0] raise;
    logic       oh_ok;
    int         exp_idx[4];
    logic [7:0] exp_res[4];

    rst        = 1'b1;
    req        = 2'b00;
    operand    = 16'h0000;
    force_done = 1'b0;
    inv_lat    = 8;

    vecs[0] = '{0, 8'h02, 8,  -1, 2'b01, 10, 8'h8E, 1'b0, 1};
    vecs[1] = '{1, 8'h00, 8,  -1, 2'b10, 1,  8'h00, 1'b1, -1};
    vecs[2] = '{1, 8'h03, 3,  -1, 2'b10, 5,  8'hF4, 1'b0, 1};
    vecs[3] = '{0, 8'h01, 1,  -1, 2'b01, 3,  8'h01, 1'b0, 1};
    vecs[4] = '{1, 8'h02, 32, -1, 2'b10, 34, 8'h8E, 1'b0, 1};   // done lands on the last wait cycle
    vecs[5] = '{0, 8'h05, 0,  40, 2'b01, 34, 8'h00, 1'b1, 1};   // timeout, then late done dropped
    vecs[6] = '{0, 8'h00, 8,  -1, 2'b01, 1,  8'h00, 1'b1, -1};
    vecs[7] = '{1, 8'h8E, 2,  -1, 2'b10, 4,  8'h02, 1'b0, 1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {gnt, done, result, err, inv_start, inv_operand}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Round-robin with both requesters continuously re-raising.
    do_reset();
    inv_lat = 2;
    exp_idx = '{0, 1, 0, 1};
    exp_res = '{8'h8E, 8'hF4, 8'h8E, 8'hF4};
    n = 0;
    ns = 0;
    raise = 2'b00;
    oh_ok = 1'b1;
    @(negedge clk);
    operand = {8'h03, 8'h02};
    req = 2'b11;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req = req | raise;
      raise = 2'b00;
      if (gnt != 2'b00 && !$onehot(gnt)) oh_ok = 1'b0;
      if (done != 2'b00 && !$onehot(done)) oh_ok = 1'b0;
      if (inv_start && ns < 4) begin
        s_cyc[ns] = c;
        ns++;
      end
      if (done != 2'b00 && n < 4) begin
        d_idx[n] = done[1] ? 1 : 0;
        d_cyc[n] = c;
        d_res[n] = result;
        n++;
        raise = done;
        req = req & ~done;
      end
    end
    req = 2'b00;
    chk("rr n_done", n, 4);
    chk("rr n_start", ns, 4);
    chk("rr onehot", oh_ok, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        chk($sformatf("rr%0d owner", i), d_idx[i], exp_idx[i]);
        chk($sformatf("rr%0d result", i), d_res[i], exp_res[i]);
        chk($sformatf("rr%0d done_cyc", i), d_cyc[i], 4 + 5 * i);
      end
      if (i < ns) chk($sformatf("rr%0d start_cyc", i), s_cyc[i], 1 + 5 * i);
    end
    repeat (3) @(negedge clk);

    // Reset while the FSM is waiting on the inverter.
    inv_lat = 20;
    @(negedge clk);
    operand[7:0] = 8'h07;
    req[0] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 4) chk("mid_wait gnt_operand", {gnt, inv_operand}, {2'b01, 8'h07});
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_wait reset_outputs", {gnt, done, result, err, inv_start, inv_operand}, 0);
    rst = 1'b0;
    req = 2'b00;
    repeat (2) @(negedge clk);
    run_vec("after_rst", '{0, 8'h01, 4, -1, 2'b01, 6, 8'h01, 1'b0, 1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
